// File: rtl/btn_pkg.sv
// Shared definitions for the button event sequencer:
// event type codes and per-button FSM state encodings.
package btn_pkg;

    // Event type carried on evt_type
    localparam logic EVT_PRESS  = 1'b0;
    localparam logic EVT_REPEAT = 1'b1;

    // Per-button hold/repeat state
    typedef enum logic [1:0] {
        BTN_IDLE = 2'b00,
        BTN_HOLD = 2'b01,
        BTN_RPT  = 2'b10
    } btn_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or
// after ptr_i, wrapping to index 0. The pointer lives in the caller.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [N-1:0] hi_req;
    logic [N-1:0] pick;
    logic         found;

    // Prefer requests at/after the pointer, else fall back to the
    // lowest request overall (the wrapped part of the ring).
    always_comb begin
        hi_req = '0;
        for (int k = 0; k < N; k++) begin
            hi_req[k] = req_i[k] && (k >= int'(ptr_i));
        end
        pick = (|hi_req) ? hi_req : req_i;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pick[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = W'(k);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into PRESS / REPEAT events and
// serialises them onto one valid/ready channel via round-robin.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int ID_W         = 2,
    parameter int CNT_W        = 10,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic               master_clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_stable,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic               evt_type,
    output logic               evt_drop
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] press_pend;
    logic [NUM_BTN-1:0] rpt_pend;
    logic [NUM_BTN-1:0] drop_vec;
    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] clr_press;
    logic [NUM_BTN-1:0] clr_rpt;
    logic [ID_W-1:0]    win_idx;
    logic               win_any;
    logic               win_type;
    logic               load;

    logic               evt_valid_q;
    logic [ID_W-1:0]    evt_id_q;
    logic               evt_type_q;
    logic [ID_W-1:0]    ptr_q;

    // Previous levels; loading during reset too means a button held
    // through reset never looks like a fresh press.
    always_ff @(posedge master_clk) begin
        btn_prev_q <= btn_stable;
    end

    assign rise = btn_stable & ~btn_prev_q;

    // Per-button hold/repeat FSM with its tick counter and
    // pending flags. A set in the same cycle as a grant-clear wins.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_state_e       st_q;
        logic [CNT_W-1:0] cnt_q;
        logic             press_q;
        logic             rpt_q;
        logic             drop_q;

        // State, counter and pending bookkeeping for one button
        always_ff @(posedge master_clk) begin
            if (rst) begin
                st_q    <= BTN_IDLE;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rpt_q   <= 1'b0;
                drop_q  <= 1'b0;
            end else begin
                drop_q <= 1'b0;
                if (clr_press[g]) begin
                    press_q <= 1'b0;
                end
                if (clr_rpt[g]) begin
                    rpt_q <= 1'b0;
                end
                unique case (st_q)
                    BTN_IDLE: begin
                        if (rise[g]) begin
                            st_q    <= BTN_HOLD;
                            cnt_q   <= '0;
                            press_q <= 1'b1;
                        end
                    end
                    BTN_HOLD: begin
                        if (!btn_stable[g]) begin
                            st_q  <= BTN_IDLE;
                            cnt_q <= '0;
                            rpt_q <= 1'b0;
                        end else if (tick) begin
                            if (cnt_q == HOLD_LAST) begin
                                st_q   <= BTN_RPT;
                                cnt_q  <= '0;
                                rpt_q  <= 1'b1;
                                drop_q <= rpt_q & ~clr_rpt[g];
                            end else if (cnt_q != '1) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    BTN_RPT: begin
                        if (!btn_stable[g]) begin
                            st_q  <= BTN_IDLE;
                            cnt_q <= '0;
                            rpt_q <= 1'b0;
                        end else if (tick) begin
                            if (cnt_q == RPT_LAST) begin
                                cnt_q  <= '0;
                                rpt_q  <= 1'b1;
                                drop_q <= rpt_q & ~clr_rpt[g];
                            end else if (cnt_q != '1) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        st_q  <= BTN_IDLE;
                        cnt_q <= '0;
                        rpt_q <= 1'b0;
                    end
                endcase
            end
        end

        assign press_pend[g] = press_q;
        assign rpt_pend[g]   = rpt_q;
        assign drop_vec[g]   = drop_q;
    end

    assign req = press_pend | rpt_pend;

    rr_arbiter #(
        .N (NUM_BTN),
        .W (ID_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // Output register is free when empty or being consumed
    assign load = ~evt_valid_q | evt_ready;

    // PRESS outranks REPEAT inside the winning button
    assign win_type  = (|(grant & press_pend)) ? EVT_PRESS : EVT_REPEAT;
    assign clr_press = load ? (grant & press_pend) : '0;
    assign clr_rpt   = load ? (grant & ~press_pend) : '0;

    // Output register and round-robin pointer
    always_ff @(posedge master_clk) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= EVT_PRESS;
            ptr_q       <= '0;
        end else if (load) begin
            if (win_any) begin
                evt_valid_q <= 1'b1;
                evt_id_q    <= win_idx;
                evt_type_q  <= win_type;
                ptr_q       <= (win_idx == LAST_ID) ? '0
                                                    : win_idx + ID_W'(1);
            end else begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_type  = evt_type_q;
    assign evt_drop  = |drop_vec;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with short hold/repeat times.
module tb_btn_event_ctrl;

    logic       master_clk;
    logic       rst;
    logic       tick;
    logic [3:0] btn_stable;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_type;
    logic       evt_drop;

    int n_cmp = 0;
    int n_bad = 0;
    int n_drop = 0;
    logic [2:0] log_q[$];

    btn_event_ctrl #(
        .NUM_BTN      (4),
        .ID_W         (2),
        .CNT_W        (10),
        .HOLD_TICKS   (5),
        .REPEAT_TICKS (2)
    ) dut (
        .master_clk (master_clk),
        .rst        (rst),
        .tick       (tick),
        .btn_stable (btn_stable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_type   (evt_type),
        .evt_drop   (evt_drop)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    // Record handshakes and drop pulses just before each rising edge
    always begin
        @(negedge master_clk);
        #4;
        if (!rst && evt_valid && evt_ready) log_q.push_back({evt_id, evt_type});
        if (!rst && evt_drop) n_drop++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge master_clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] id,
                           input logic typ);
        chk(tag, {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, id, typ});
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        btn_stable = 4'b0000;
        evt_ready = 1'b1;
        cyc(2);
        chk("rst_out", {evt_valid, evt_id, evt_type, evt_drop}, 0);
        rst = 1'b0;

        // 1: single short press of btn 2
        btn_stable = 4'b0100;
        cyc(1);
        chk("t1_lat1", evt_valid, 0);
        cyc(1);
        chk_evt("t1_press", 2'd2, 1'b0);
        cyc(1);
        chk("t1_idle", evt_valid, 0);
        for (int k = 0; k < 3; k++) tick_pulse();
        btn_stable = 4'b0000;
        cyc(3);
        chk("t1_nvalid", evt_valid, 0);
        chk("t1_count", log_q.size(), 1);
        chk("t1_log", log_q[0], 3'b100);
        log_q.delete();

        // 2: hold btn 1 for 12 ticks
        btn_stable = 4'b0010;
        cyc(2);
        chk_evt("t2_press", 2'd1, 1'b0);
        cyc(1);
        for (int k = 1; k <= 12; k++) begin
            logic fire;
            fire = (k == 5) || (k == 7) || (k == 9) || (k == 11);
            tick_pulse();
            cyc(1);
            chk($sformatf("t2_v_tick%0d", k), evt_valid, fire);
            if (fire) chk($sformatf("t2_rpt%0d", k), {evt_id, evt_type}, 3'b011);
            cyc(1);
        end
        btn_stable = 4'b0000;
        cyc(4);
        chk("t2_nvalid", evt_valid, 0);
        chk("t2_count", log_q.size(), 5);
        chk("t2_log0", log_q[0], 3'b010);
        for (int i = 1; i < 5; i++) chk($sformatf("t2_log%0d", i), log_q[i], 3'b011);
        chk("t2_drops", n_drop, 0);

        // 3: simultaneous rises after a fresh reset
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        log_q.delete();
        btn_stable = 4'b1011;
        cyc(2);
        chk_evt("t3_a0", 2'd0, 1'b0);
        cyc(1);
        chk_evt("t3_a1", 2'd1, 1'b0);
        cyc(1);
        chk_evt("t3_a3", 2'd3, 1'b0);
        cyc(1);
        chk("t3_aend", evt_valid, 0);
        btn_stable = 4'b0000;
        cyc(2);
        btn_stable = 4'b1001;
        cyc(2);
        chk_evt("t3_b0", 2'd0, 1'b0);
        cyc(1);
        chk_evt("t3_b3", 2'd3, 1'b0);
        cyc(1);
        chk("t3_bend", evt_valid, 0);
        btn_stable = 4'b0000;
        cyc(2);
        chk("t3_count", log_q.size(), 5);

        // 4: stall with btn 0 held, repeats overflow into drops
        n_drop = 0;
        evt_ready = 1'b0;
        btn_stable = 4'b0001;
        cyc(2);
        chk_evt("t4_press", 2'd0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick_pulse();
            chk($sformatf("t4_drop%0d", k), evt_drop, (k == 7) || (k == 9));
            cyc(1);
            chk_evt($sformatf("t4_hold%0d", k), 2'd0, 1'b0);
        end
        chk("t4_ndrop", n_drop, 2);
        evt_ready = 1'b1;
        cyc(1);
        chk_evt("t4_rpt", 2'd0, 1'b1);
        cyc(1);
        chk("t4_end", evt_valid, 0);
        btn_stable = 4'b0000;
        cyc(2);

        // 5: short btn 3 press while btn 1 event is stalled
        evt_ready = 1'b0;
        btn_stable = 4'b0010;
        cyc(2);
        chk_evt("t5_b1", 2'd1, 1'b0);
        btn_stable = 4'b1010;
        cyc(2);
        btn_stable = 4'b0010;
        cyc(3);
        chk_evt("t5_held", 2'd1, 1'b0);
        evt_ready = 1'b1;
        cyc(1);
        chk_evt("t5_b3", 2'd3, 1'b0);
        cyc(1);
        chk("t5_end", evt_valid, 0);
        btn_stable = 4'b0000;
        cyc(2);

        // 6: reset while an event is presented and two are pending
        evt_ready = 1'b0;
        btn_stable = 4'b0111;
        cyc(2);
        chk_evt("t6_pre", 2'd0, 1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst", {evt_valid, evt_id, evt_type, evt_drop}, 0);
        log_q.delete();
        evt_ready = 1'b1;
        cyc(5);
        chk("t6_quiet", evt_valid, 0);
        chk("t6_nolog", log_q.size(), 0);
        btn_stable = 4'b0110;
        cyc(2);
        chk("t6_rel", evt_valid, 0);
        btn_stable = 4'b0111;
        cyc(2);
        chk_evt("t6_repress", 2'd0, 1'b0);
        cyc(1);
        chk("t6_end", evt_valid, 0);
        chk("t6_count", log_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
